rgb_to_hsv: RTL and testbench
=============================

# rgb_to_hsv

Pipelined RGB-to-HSV converter with a valid strobe. It accepts one 8-bit RGB pixel per clock and produces H/S/V in exactly the fixed-point format consumed by the HSV-to-RGB back-converter: H in degrees 0..359, S as an 11-bit fraction, and V as 8 bits. It sits at the front of the HSV processing path in the HDR video pipeline, ahead of any per-channel V/S manipulation. It has a fixed latency and no backpressure.

## Interface
- No parameters. Localparam `LATENCY` = 22 is exported via the package.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `r`/`g`/`b` carry a pixel this cycle.
- `r`, `g`, `b` in 8 each: unsigned pixel components.
- `out_valid` out 1: `H`/`S`/`V` carry a result this cycle.
- `H` out 9: hue in degrees, 0..359.
- `S` out 11: saturation = C·2048/V, truncated, clipped to 2047.
- `V` out 8: max(r,g,b).

## Operation
- Per pixel:
  - max = max(r,g,b), min = min(r,g,b), C = max − min.
  - V = max.
- Max-channel selection uses tie priority r > g > b.
- Hue numerator d (signed, 9 bits):
  - max=r: d = g − b, offset 0.
  - max=g: d = b − r, offset 120.
  - max=b: d = r − g, offset 240.
- q = floor(60·|d| / C). Division is on the magnitude and truncates toward zero; q is in 0..60.
- H = offset + q if d ≥ 0, else offset − q.
- Hue wrap: if the result is negative, add 360. A result of 360 outputs 0, so H is never ≥ 360.
- S = floor((C << 11) / V). A quotient of 2048 (min = 0, C = V > 0) is clipped to 2047.
- Degenerate inputs:
  - C = 0: H = 0, and the hue division result is ignored.
  - V = 0: S = 0, and the S division result is ignored. There is no divide-by-zero hazard at the output.
- Both divisions use unsigned 19-bit numerators and 8-bit denominators. The hue numerator, 60·|d| ≤ 15300, is zero-extended. Quotient widths: 19 bits internal, truncated to the output widths only after clipping.
- Every stage is enabled every cycle and there is no stall. `in_valid` travels through a LATENCY-deep shift register alongside the data.
- Data with `in_valid` = 0 still propagates. The outputs are don't-care while `out_valid` = 0, but they must not be X after reset.

## Timing
- Latency: a pixel sampled at edge N with `in_valid` = 1 appears at edge N+22 with `out_valid` = 1.
- Throughput: 1 pixel per clock, including fully back-to-back streams.
- Stage breakdown:
  - 1 cycle: input register, max/min, sector select.
  - 1 cycle: C, d, 60·|d|, C<<11.
  - 19 cycles: `hsv_div_pipe`, one quotient bit per stage, two instances in parallel.
  - 1 cycle: sign/offset/wrap for H, clip and zero-force for S, output register.
- Sector, offset, sign, V and the C=0 / V=0 flags are delay-matched to the divider: 19 stages, registered alongside it.
- Reset behaviour:
  - While `rst` = 0: `out_valid` = 0 and `H`/`S`/`V` = 0. All valid shift-register bits clear asynchronously.
  - Reset asserted mid-stream: all in-flight pixels are dropped and no `out_valid` pulse follows.
  - After release, the first `out_valid` can come no earlier than 22 cycles after the first sampled `in_valid`.
- Isolated single-cycle `in_valid` pulses produce single-cycle `out_valid` pulses exactly 22 cycles later. The gaps are preserved.

## Structure
- Package `hsv_pkg` holds:
  - `H_W`=9, `S_W`=11, `V_W`=8.
  - `S_ONE`=2048, `S_MAX`=2047.
  - `HUE_SECTOR`=60, `HUE_FULL`=360.
  - `DIV_NW`=19, `DIV_DW`=8.
  - `LATENCY`=22.
  - The sector enum {SEC_R, SEC_G, SEC_B}.
- Sub-module `hsv_div_pipe`:
  - Pipelined restoring unsigned divider, `DIV_NW` stages.
  - Inputs: numer, denom, and a side-band payload that is delayed in lock-step.
  - Outputs: quotient and delayed payload.
  - Instantiated twice, for H and S. The S instance carries V and the flags as payload.
- Top level: max/min/sector logic, the valid shift register, and the output stage.

## Test plan
- (255,0,0) → H=0, S=2047, V=255. (0,255,0) → H=120, S=2047. (0,0,255) → H=240, S=2047. Each `out_valid` exactly 22 cycles after its input.
- (255,128,0) → H=30, S=2047, V=255. (255,0,128) → H=330. (255,0,1) → q=0 wraps to H=0. (200,100,100) → H=0, S=1024, V=200.
- Degenerate inputs: (128,128,128) → H=0, S=0, V=128. (0,0,0) → H=0, S=0, V=0. Ties such as (200,200,50) → max=r branch, H=60.
- Back-to-back stream of 1000 random pixels with random `in_valid` gaps → every output matches a bit-exact reference model, and the `out_valid` pattern equals the input pattern delayed by 22.
- Assert `rst` low for 3 cycles while 10 pixels are in flight → `out_valid`/`H`/`S`/`V` go to 0 immediately and no stale pixel emerges. A pixel sent 1 cycle after release appears 22 cycles later.
- Round trip: feed outputs into the HSV-to-RGB block over a full RGB sweep → reconstructed r/g/b within ±2 LSB of the originals.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared widths, constants and sector encoding for the RGB/HSV conversion path.
package hsv_pkg;

  localparam int H_W        = 9;
  localparam int S_W        = 11;
  localparam int V_W        = 8;
  localparam int S_ONE      = 2048;
  localparam int S_MAX      = 2047;
  localparam int HUE_SECTOR = 60;
  localparam int HUE_FULL   = 360;
  localparam int DIV_NW     = 19;
  localparam int DIV_DW     = 8;
  localparam int LATENCY    = 22;

  typedef enum logic [1:0] {
    SEC_R = 2'd0,
    SEC_G = 2'd1,
    SEC_B = 2'd2
  } sector_e;

  function automatic logic [H_W-1:0] sector_offset(input sector_e sec);
    logic [H_W-1:0] off;
    off = '0;
    case (sec)
      SEC_G:   off = 9'd120;
      SEC_B:   off = 9'd240;
      default: off = '0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/hsv_div_pipe.sv
// Pipelined restoring unsigned divider, one quotient bit per stage (NW-cycle latency,
// never stalls); the payload is delayed in lock-step with the quotient.
module hsv_div_pipe
  import hsv_pkg::*;
#(
  parameter int NW = DIV_NW,
  parameter int DW = DIV_DW,
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] numer_i,
  input  logic [DW-1:0] denom_i,
  input  logic [PW-1:0] pay_i,
  output logic [NW-1:0] quo_o,
  output logic [PW-1:0] pay_o
);

  // nq_q holds unconsumed numerator bits on top and quotient bits shifted in below.
  logic [NW-1:0] nq_q  [NW];
  logic [PW-1:0] pay_q [NW];
  logic [DW-1:0] rem_q [NW-1];
  logic [DW-1:0] den_q [NW-1];

  for (genvar s = 0; s < NW; s++) begin : g_stage
    logic [NW-1:0] nq_in;
    logic [DW-1:0] rem_in;
    logic [DW-1:0] den_in;
    logic [PW-1:0] pay_in;
    logic [DW:0]   trial;
    logic          take;

    if (s == 0) begin : g_head
      assign nq_in  = numer_i;
      assign rem_in = '0;
      assign den_in = denom_i;
      assign pay_in = pay_i;
    end else begin : g_body
      assign nq_in  = nq_q[s-1];
      assign rem_in = rem_q[s-1];
      assign den_in = den_q[s-1];
      assign pay_in = pay_q[s-1];
    end

    assign trial = {rem_in, nq_in[NW-1]};
    assign take  = (trial >= {1'b0, den_in});

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        nq_q[s]  <= '0;
        pay_q[s] <= '0;
      end else begin
        nq_q[s]  <= {nq_in[NW-2:0], take};
        pay_q[s] <= pay_in;
      end
    end

    if (s < NW-1) begin : g_carry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rem_q[s] <= '0;
          den_q[s] <= '0;
        end else begin
          rem_q[s] <= take ? DW'(trial - {1'b0, den_in}) : DW'(trial);
          den_q[s] <= den_in;
        end
      end
    end
  end

  assign quo_o = nq_q[NW-1];
  assign pay_o = pay_q[NW-1];

endmodule

// File: rtl/rgb_to_hsv.sv
// RGB888 to HSV converter: H in degrees, S as 11-bit fraction, V = max channel.
// Fixed LATENCY-cycle pipeline, one pixel per clock, no backpressure.
module rgb_to_hsv
  import hsv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [V_W-1:0] r,
  input  logic [V_W-1:0] g,
  input  logic [V_W-1:0] b,
  output logic           out_valid,
  output logic [H_W-1:0] H,
  output logic [S_W-1:0] S,
  output logic [V_W-1:0] V
);

  localparam int HPW = 3;
  localparam int SPW = V_W + 2;

  // Stage 1: input register with max/min and tie-prioritised sector.
  logic [V_W-1:0] max_d, min_d;
  sector_e        sec_d;
  logic [V_W-1:0] s1_r_q, s1_g_q, s1_b_q, s1_max_q, s1_min_q;
  sector_e        s1_sec_q;

  always_comb begin
    sec_d = SEC_B;
    max_d = b;
    if (r >= g && r >= b) begin
      sec_d = SEC_R;
      max_d = r;
    end else if (g >= b) begin
      sec_d = SEC_G;
      max_d = g;
    end
    min_d = r;
    if (g < min_d) min_d = g;
    if (b < min_d) min_d = b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r_q   <= '0;
      s1_g_q   <= '0;
      s1_b_q   <= '0;
      s1_max_q <= '0;
      s1_min_q <= '0;
      s1_sec_q <= SEC_R;
    end else begin
      s1_r_q   <= r;
      s1_g_q   <= g;
      s1_b_q   <= b;
      s1_max_q <= max_d;
      s1_min_q <= min_d;
      s1_sec_q <= sec_d;
    end
  end

  // Stage 2: chroma, hue numerator magnitude/sign and divider operands.
  logic [V_W-1:0]    c_d, dx_d, dy_d, mag_d;
  logic              neg_d;
  logic [DIV_NW-1:0] h_num_d, s_num_d;

  always_comb begin
    c_d  = s1_max_q - s1_min_q;
    dx_d = s1_g_q;
    dy_d = s1_b_q;
    case (s1_sec_q)
      SEC_G: begin
        dx_d = s1_b_q;
        dy_d = s1_r_q;
      end
      SEC_B: begin
        dx_d = s1_r_q;
        dy_d = s1_g_q;
      end
      default: ;
    endcase
    neg_d   = (dx_d < dy_d);
    mag_d   = neg_d ? (dy_d - dx_d) : (dx_d - dy_d);
    h_num_d = DIV_NW'(mag_d) * DIV_NW'(HUE_SECTOR);
    s_num_d = DIV_NW'(c_d) << $clog2(S_ONE);
  end

  logic [DIV_NW-1:0] s2_h_num_q, s2_s_num_q;
  logic [V_W-1:0]    s2_c_q, s2_v_q;
  logic              s2_neg_q, s2_cz_q, s2_vz_q;
  sector_e           s2_sec_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_h_num_q <= '0;
      s2_s_num_q <= '0;
      s2_c_q     <= '0;
      s2_v_q     <= '0;
      s2_neg_q   <= 1'b0;
      s2_cz_q    <= 1'b0;
      s2_vz_q    <= 1'b0;
      s2_sec_q   <= SEC_R;
    end else begin
      s2_h_num_q <= h_num_d;
      s2_s_num_q <= s_num_d;
      s2_c_q     <= c_d;
      s2_v_q     <= s1_max_q;
      s2_neg_q   <= neg_d;
      s2_cz_q    <= (c_d == '0);
      s2_vz_q    <= (s1_max_q == '0);
      s2_sec_q   <= s1_sec_q;
    end
  end

  // Two parallel dividers; control and V ride along as payload.
  logic [DIV_NW-1:0] h_quo, s_quo;
  logic [HPW-1:0]    h_pay;
  logic [SPW-1:0]    s_pay;

  hsv_div_pipe #(.NW(DIV_NW), .DW(DIV_DW), .PW(HPW)) u_div_h (
    .clk     (clk),
    .rst     (rst),
    .numer_i (s2_h_num_q),
    .denom_i (s2_c_q),
    .pay_i   ({s2_neg_q, s2_sec_q}),
    .quo_o   (h_quo),
    .pay_o   (h_pay)
  );

  hsv_div_pipe #(.NW(DIV_NW), .DW(DIV_DW), .PW(SPW)) u_div_s (
    .clk     (clk),
    .rst     (rst),
    .numer_i (s2_s_num_q),
    .denom_i (s2_v_q),
    .pay_i   ({s2_v_q, s2_cz_q, s2_vz_q}),
    .quo_o   (s_quo),
    .pay_o   (s_pay)
  );

  logic           h_neg, h_cz, h_vz;
  sector_e        h_sec;
  logic [V_W-1:0] v_dly;

  assign h_neg = h_pay[2];
  assign h_sec = sector_e'(h_pay[1:0]);
  assign v_dly = s_pay[SPW-1:2];
  assign h_cz  = s_pay[1];
  assign h_vz  = s_pay[0];

  // Output stage: signed offset/wrap for H, clip and zero-force for S.
  logic signed [DIV_NW+1:0] off_s, q_s, h_raw;
  logic [H_W-1:0]           h_d, h_q;
  logic [S_W-1:0]           s_d, s_q;
  logic [V_W-1:0]           v_q;

  always_comb begin
    off_s = {{(DIV_NW+2-H_W){1'b0}}, sector_offset(h_sec)};
    q_s   = {2'b00, h_quo};
    h_raw = h_neg ? (off_s - q_s) : (off_s + q_s);
    h_d   = '0;
    if (!h_cz) begin
      if (h_raw < 0)             h_d = H_W'(h_raw + HUE_FULL);
      else if (h_raw >= HUE_FULL) h_d = '0;
      else                        h_d = H_W'(h_raw);
    end
    s_d = '0;
    if (!h_vz) s_d = (s_quo > DIV_NW'(S_MAX)) ? S_W'(S_MAX) : S_W'(s_quo);
  end

  logic [LATENCY-1:0] vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      h_q   <= '0;
      s_q   <= '0;
      v_q   <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], in_valid};
      h_q   <= h_d;
      s_q   <= s_d;
      v_q   <= v_dly;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign H         = h_q;
  assign S         = s_q;
  assign V         = v_q;

endmodule

// File: tb/tb_rgb_to_hsv.sv
// Scoreboard bench for rgb_to_hsv: directed vectors, random stream, reset behaviour.
module tb_rgb_to_hsv;
  import hsv_pkg::*;

  typedef struct {
    int h;
    int s;
    int v;
    int t;
  } exp_t;

  localparam int NV   = 14;
  localparam int NPIX = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       out_valid;
  logic [8:0] H;
  logic [10:0] S;
  logic [7:0] V;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // r, g, b, expected H, S, V
  int tv [NV][6] = '{
    '{255,   0,   0,   0, 2047, 255},
    '{  0, 255,   0, 120, 2047, 255},
    '{  0,   0, 255, 240, 2047, 255},
    '{255, 128,   0,  30, 2047, 255},
    '{255,   0, 128, 330, 2047, 255},
    '{255,   0,   1,   0, 2047, 255},
    '{200, 100, 100,   0, 1024, 200},
    '{128, 128, 128,   0,    0, 128},
    '{  0,   0,   0,   0,    0,   0},
    '{200, 200,  50,  60, 1536, 200},
    '{ 50, 100, 200, 220, 1536, 200},
    '{ 10, 200, 200, 180, 1945, 200},
    '{100,  50, 255, 254, 1646, 255},
    '{  1,   0,   0,   0, 2047,   1}
  };

  rgb_to_hsv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .r         (r),
    .g         (g),
    .b         (b),
    .out_valid (out_valid),
    .H         (H),
    .S         (S),
    .V         (V)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic void ref_hsv(input int rr, input int gg, input int bb,
                                  output int h, output int s, output int v);
    int mx, mn, c, d, off, q;
    mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
    mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
    c = mx - mn;
    if (rr == mx)      begin d = gg - bb; off = 0;   end
    else if (gg == mx) begin d = bb - rr; off = 120; end
    else               begin d = rr - gg; off = 240; end
    if (c == 0) h = 0;
    else begin
      q = (60 * (d < 0 ? -d : d)) / c;
      h = (d >= 0) ? off + q : off - q;
      if (h < 0) h += 360;
      if (h >= 360) h = 0;
    end
    v = mx;
    if (mx == 0) s = 0;
    else begin
      s = (c * 2048) / mx;
      if (s > 2047) s = 2047;
    end
  endfunction

  task automatic drive(input logic vld, input int rr, input int gg, input int bb);
    @(negedge clk);
    in_valid = vld;
    r = 8'(rr);
    g = 8'(gg);
    b = 8'(bb);
  endtask

  task automatic test_reset();
    drive(1'b1, 255, 10, 20);
    drive(1'b1, 30, 200, 40);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (H !== 9'd0) begin errors++; $display("FAIL reset_H: got %0d want 0", H); end
    checks++;
    if (S !== 11'd0) begin errors++; $display("FAIL reset_S: got %0d want 0", S); end
    checks++;
    if (V !== 8'd0) begin errors++; $display("FAIL reset_V: got %0d want 0", V); end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    begin
      int seen_vld;
      seen_vld = 0;
      for (int k = 0; k < LATENCY + 4; k++) begin
        @(negedge clk);
        if (out_valid !== 1'b0) seen_vld++;
      end
      checks++;
      if (seen_vld != 0) begin errors++; $display("FAIL reset_quiet: got %0d out_valid cycles want 0", seen_vld); end
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      logic got;
      drive(1'b1, tv[i][0], tv[i][1], tv[i][2]);
      e.h = tv[i][3]; e.s = tv[i][4]; e.v = tv[i][5]; e.t = cyc + 1;
      exp_q.push_back(e);
      drive(1'b0, 0, 0, 0);
      got = 1'b0;
      for (int k = 0; k < LATENCY + 4 && !got; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          got = 1'b1;
          e = exp_q.pop_front();
          checks++;
          if (H !== 9'(e.h) || S !== 11'(e.s) || V !== 8'(e.v)) begin
            errors++;
            $display("FAIL directed_%0d: got H=%0d S=%0d V=%0d want H=%0d S=%0d V=%0d",
                     i, H, S, V, e.h, e.s, e.v);
          end
          // the result is presented to the capturing edge after this one
          checks++;
          if (cyc + 1 - e.t != LATENCY) begin
            errors++;
            $display("FAIL directed_%0d_latency: got %0d want %0d", i, cyc + 1 - e.t, LATENCY);
          end
        end
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL directed_%0d_timeout: got no out_valid want one within %0d cycles", i, LATENCY + 4);
        exp_q.delete();
      end else begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL directed_%0d_pulse: got out_valid=%b want 0", i, out_valid); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   pr [NPIX];
    int   pg [NPIX];
    int   pb [NPIX];
    logic pv [NPIX];
    int   nv, seen, extra, bad;
    nv = 0; seen = 0; extra = 0; bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      pr[i] = int'($urandom_range(0, 255));
      pg[i] = int'($urandom_range(0, 255));
      pb[i] = int'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: pg[i] = pr[i];
        1: pb[i] = pg[i];
        2: begin pg[i] = pr[i]; pb[i] = pr[i]; end
        3: pb[i] = 0;
        default: ;
      endcase
      pv[i] = ($urandom_range(0, 3) != 0);
      if (pv[i]) nv++;
    end
    fork
      begin
        exp_t ed;
        for (int i = 0; i < NPIX; i++) begin
          drive(pv[i], pr[i], pg[i], pb[i]);
          if (pv[i]) begin
            ref_hsv(pr[i], pg[i], pb[i], ed.h, ed.s, ed.v);
            ed.t = cyc + 1;
            exp_q.push_back(ed);
          end
        end
        drive(1'b0, 0, 0, 0);
      end
      begin
        exp_t ec;
        for (int k = 0; k < NPIX + LATENCY + 6; k++) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) extra++;
            else begin
              ec = exp_q.pop_front();
              seen++;
              checks++;
              if (H !== 9'(ec.h) || S !== 11'(ec.s) || V !== 8'(ec.v) || cyc + 1 - ec.t != LATENCY) begin
                errors++;
                if (bad < 10)
                  $display("FAIL stream_pixel_%0d: got H=%0d S=%0d V=%0d lat=%0d want H=%0d S=%0d V=%0d lat=%0d",
                           seen, H, S, V, cyc + 1 - ec.t, ec.h, ec.s, ec.v, LATENCY);
                bad++;
              end
            end
          end
        end
      end
    join
    checks++;
    if (extra != 0) begin errors++; $display("FAIL stream_extra: got %0d unexpected outputs want 0", extra); end
    checks++;
    if (seen != nv) begin errors++; $display("FAIL stream_count: got %0d outputs want %0d", seen, nv); end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int   seen, stale;
    seen = 0; stale = 0;
    for (int i = 0; i < 10; i++)
      drive(1'b1, int'($urandom_range(1, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || H !== 9'd0 || S !== 11'd0 || V !== 8'd0) begin
      errors++;
      $display("FAIL midreset_zero: got vld=%b H=%0d S=%0d V=%0d want all 0", out_valid, H, S, V);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 10, 20, 30);
    e.h = 210; e.s = 1365; e.v = 30; e.t = cyc + 1;
    exp_q.push_back(e);
    drive(1'b0, 0, 0, 0);
    for (int k = 0; k < LATENCY + 30; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) stale++;
        else begin
          e = exp_q.pop_front();
          seen++;
          checks++;
          if (H !== 9'(e.h) || S !== 11'(e.s) || V !== 8'(e.v) || cyc + 1 - e.t != LATENCY) begin
            errors++;
            $display("FAIL midreset_pixel: got H=%0d S=%0d V=%0d lat=%0d want H=%0d S=%0d V=%0d lat=%0d",
                     H, S, V, cyc + 1 - e.t, e.h, e.s, e.v, LATENCY);
          end
        end
      end
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL midreset_stale: got %0d stale outputs want 0", stale); end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL midreset_count: got %0d outputs want 1", seen); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
